// File: rtl/tetris_preview_pkg.sv
// tetris_preview_pkg
//   Shared definitions for the next-piece preview renderer:
//   - piece type encoding (I,O,T,S,Z,J,L = 0..6)
//   - RGB888 colour per piece type, white for anything else
//   - default dot field widths (column in the upper bits, row in the lower bits)
package tetris_preview_pkg;

    localparam int DEF_COL_W = 5;
    localparam int DEF_ROW_W = 5;
    localparam int DEF_DOT_W = DEF_COL_W + DEF_ROW_W;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_e;

    localparam logic [23:0] COLOUR_I       = 24'h00FFFF;
    localparam logic [23:0] COLOUR_O       = 24'hFFFF00;
    localparam logic [23:0] COLOUR_T       = 24'h800080;
    localparam logic [23:0] COLOUR_S       = 24'h00FF00;
    localparam logic [23:0] COLOUR_Z       = 24'hFF0000;
    localparam logic [23:0] COLOUR_J       = 24'h0000FF;
    localparam logic [23:0] COLOUR_L       = 24'hFFA500;
    localparam logic [23:0] COLOUR_DEFAULT = 24'hFFFFFF;

    // Type is passed zero-extended so any TYPE_W works; unknown types are white.
    function automatic logic [23:0] colour_lut(input logic [31:0] t);
        logic [23:0] c;
        case (t)
            32'(PIECE_I): c = COLOUR_I;
            32'(PIECE_O): c = COLOUR_O;
            32'(PIECE_T): c = COLOUR_T;
            32'(PIECE_S): c = COLOUR_S;
            32'(PIECE_Z): c = COLOUR_Z;
            32'(PIECE_J): c = COLOUR_J;
            32'(PIECE_L): c = COLOUR_L;
            default:      c = COLOUR_DEFAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tetris_preview_renderer_cell_hit.sv
// preview_cell_hit
//   Combinational test of whether the current pixel lies inside the visible
//   part of one preview cell (the GAP pixels at the left/top are blank).
//   Ports:
//     col, row       : cell coordinates of the dot
//     x_addr, y_addr : current pixel
//     hit            : pixel is inside the cell, bounds inclusive
//   Bounds are evaluated at BW bits so a cell past the address range is
//   simply never matched (clipped) instead of wrapping onto low addresses.
module preview_cell_hit #(
    parameter int COL_W   = 5,
    parameter int ROW_W   = 5,
    parameter int ADDR_W  = 9,
    parameter int BW      = 18,
    parameter int CELL_W  = 10,
    parameter int CELL_H  = 10,
    parameter int GAP     = 1,
    parameter int X_START = 0,
    parameter int Y_START = 50
) (
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [ADDR_W-1:0] y_addr,
    output logic              hit
);

    logic [BW-1:0] x_ext, y_ext;
    logic [BW-1:0] x_lo, x_hi, y_lo, y_hi;

    assign x_ext = BW'(x_addr);
    assign y_ext = BW'(y_addr);

    assign x_lo = BW'(X_START) + BW'(CELL_W) * BW'(col) + BW'(GAP);
    assign x_hi = BW'(X_START) + BW'(CELL_W) * (BW'(col) + BW'(1)) - BW'(1);
    assign y_lo = BW'(Y_START) + BW'(CELL_H) * BW'(row) + BW'(GAP);
    assign y_hi = BW'(Y_START) + BW'(CELL_H) * (BW'(row) + BW'(1)) - BW'(1);

    assign hit = (x_ext >= x_lo) && (x_ext <= x_hi) &&
                 (y_ext >= y_lo) && (y_ext <= y_hi);

endmodule

// File: rtl/tetris_preview_renderer.sv
// tetris_preview_renderer
//   Next-piece preview for the VGA pixel mux. A piece is accepted into a
//   shadow buffer over valid/ready and copied to the active piece only at
//   frame start, so a frame never shows half of two pieces.
//   Ports:
//     clk, rst          : pixel clock, asynchronous active-low reset
//     x_addr, y_addr    : current pixel
//     frame_start       : one-cycle pulse on the first pixel of a frame
//     next_valid/ready  : piece handshake, ready = no piece waiting in shadow
//     next_dots         : NUM_DOTS x {col,row}, dot 0 in the LSBs
//     next_type         : piece type (colour select)
//     preview_en        : pixel belongs to the preview (2 clk after x/y)
//     preview_data      : RGB888 colour, 0 when preview_en is low
//   Optional: define TETRIS_PREVIEW_BLINK_EN to blink a freshly swapped
//   piece for BLINK_FRAMES frames (2 frames off, 2 frames on).
module tetris_preview_renderer
    import tetris_preview_pkg::*;
#(
    parameter int NUM_DOTS     = 4,
    parameter int COL_W        = DEF_COL_W,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int TYPE_W       = 3,
    parameter int ADDR_W       = 9,
    parameter int CELL_W       = 10,
    parameter int CELL_H       = 10,
    parameter int GAP          = 1,
    parameter int X_START      = 0,
    parameter int Y_START      = 50,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_W-1:0]                 x_addr,
    input  logic [ADDR_W-1:0]                 y_addr,
    input  logic                              frame_start,
    input  logic                              next_valid,
    output logic                              next_ready,
    input  logic [NUM_DOTS*(COL_W+ROW_W)-1:0] next_dots,
    input  logic [TYPE_W-1:0]                 next_type,
    output logic                              preview_en,
    output logic [23:0]                       preview_data
);

    localparam int DOT_W  = COL_W + ROW_W;
    localparam int BW     = ADDR_W + ((COL_W > ROW_W) ? COL_W : ROW_W) + 4;
    localparam int STAGES = 2;

    logic                             pending, active_valid;
    logic [NUM_DOTS-1:0][DOT_W-1:0]   shadow_dots, active_dots, eff_dots;
    logic [TYPE_W-1:0]                shadow_type, active_type, eff_type;
    logic                             accept, swap, eff_valid, blank0;
    logic [NUM_DOTS-1:0]              hits, hit_s1;
    logic [TYPE_W-1:0]                type_s1;
    logic                             blank_s1;
    logic [STAGES:1]                  vld_pipe;

    assign next_ready = ~pending;
    assign accept     = next_valid & ~pending;
    assign swap       = frame_start & pending;

    // accept needs pending=0 and swap needs pending=1, so they never collide;
    // a piece accepted on a frame_start therefore waits for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= 1'b0;
            active_valid <= 1'b0;
            shadow_dots  <= '0;
            shadow_type  <= '0;
            active_dots  <= '0;
            active_type  <= '0;
        end else if (accept) begin
            shadow_dots <= next_dots;
            shadow_type <= next_type;
            pending     <= 1'b1;
        end else if (swap) begin
            active_dots  <= shadow_dots;
            active_type  <= shadow_type;
            active_valid <= 1'b1;
            pending      <= 1'b0;
        end
    end

    // The pixel presented on the swap cycle already sees the new piece.
    assign eff_dots  = swap ? shadow_dots : active_dots;
    assign eff_type  = swap ? shadow_type : active_type;
    assign eff_valid = active_valid | swap;

    for (genvar g = 0; g < NUM_DOTS; g++) begin : g_dot
        preview_cell_hit #(
            .COL_W  (COL_W),
            .ROW_W  (ROW_W),
            .ADDR_W (ADDR_W),
            .BW     (BW),
            .CELL_W (CELL_W),
            .CELL_H (CELL_H),
            .GAP    (GAP),
            .X_START(X_START),
            .Y_START(Y_START)
        ) u_hit (
            .col   (eff_dots[g][DOT_W-1:ROW_W]),
            .row   (eff_dots[g][ROW_W-1:0]),
            .x_addr(x_addr),
            .y_addr(y_addr),
            .hit   (hits[g])
        );
    end

`ifdef TETRIS_PREVIEW_BLINK_EN
    localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) < 2) ? 2 : $clog2(BLINK_FRAMES + 1);

    logic [BLINK_W-1:0] blink_cnt, blink_nxt;

    // Blank decision uses the post-update count so the frame_start pixel
    // already belongs to the new blink phase.
    always_comb begin
        blink_nxt = blink_cnt;
        if (swap)
            blink_nxt = BLINK_W'(BLINK_FRAMES);
        else if (frame_start && blink_cnt != '0)
            blink_nxt = blink_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink_cnt <= '0;
        else      blink_cnt <= blink_nxt;
    end

    assign blank0 = (blink_nxt != '0) & blink_nxt[1];
`else
    assign blank0 = 1'b0;
`endif

    // Stage 1: hit vector, type, blank; stage 2: enable and colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_s1       <= '0;
            type_s1      <= '0;
            blank_s1     <= 1'b0;
            vld_pipe     <= '0;
            preview_data <= '0;
        end else begin
            hit_s1      <= hits;
            type_s1     <= eff_type;
            blank_s1    <= blank0;
            vld_pipe[1] <= eff_valid;
            vld_pipe[2] <= vld_pipe[1] & (|hit_s1) & ~blank_s1;
            preview_data <= (vld_pipe[1] & (|hit_s1) & ~blank_s1)
                            ? colour_lut(32'(type_s1)) : 24'h0;
        end
    end

    assign preview_en = vld_pipe[STAGES];

endmodule

// File: tb/tb_tetris_preview_renderer.sv
module tb_tetris_preview_renderer;

    localparam int X0 = 0, Y0 = 50, CW = 10, CH = 10, GP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  x_addr, y_addr;
    logic        frame_start, next_valid, next_ready;
    logic [39:0] next_dots;
    logic [2:0]  next_type;
    logic        preview_en;
    logic [23:0] preview_data;

    always #5 clk = ~clk;

    tetris_preview_renderer dut (
        .clk(clk), .rst(rst), .x_addr(x_addr), .y_addr(y_addr),
        .frame_start(frame_start), .next_valid(next_valid), .next_ready(next_ready),
        .next_dots(next_dots), .next_type(next_type),
        .preview_en(preview_en), .preview_data(preview_data)
    );

    int checks = 0, failures = 0;

    // model state
    logic [39:0] m_shadow, m_active;
    int          m_stype, m_atype, m_blink;
    bit          m_pending, m_valid;
    bit          eq[$];
    logic [23:0] dq[$];
    bit          exp_ready;
    bit          chk_on = 0;

    function automatic logic [23:0] colour(int t);
        case (t)
            0: return 24'h00FFFF;
            1: return 24'hFFFF00;
            2: return 24'h800080;
            3: return 24'h00FF00;
            4: return 24'hFF0000;
            5: return 24'h0000FF;
            6: return 24'hFFA500;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic bit m_hit(logic [39:0] d, int x, int y);
        for (int i = 0; i < 4; i++) begin
            int c, r;
            c = int'(d[i*10+5 +: 5]);
            r = int'(d[i*10 +: 5]);
            if (x >= X0 + CW*c + GP && x <= X0 + CW*(c+1) - 1 &&
                y >= Y0 + CH*r + GP && y <= Y0 + CH*(r+1) - 1)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [39:0] mk(int c0, int r0, int c1, int r1, int c2, int r2, int c3, int r3);
        logic [4:0] a0, b0, a1, b1, a2, b2, a3, b3;
        a0 = c0[4:0]; b0 = r0[4:0]; a1 = c1[4:0]; b1 = r1[4:0];
        a2 = c2[4:0]; b2 = r2[4:0]; a3 = c3[4:0]; b3 = r3[4:0];
        return {a3, b3, a2, b2, a1, b1, a0, b0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: each negedge, outputs belong to the pixel driven two steps earlier.
    always @(negedge clk) begin
        if (chk_on && eq.size() >= 3) begin
            bit          e;
            logic [23:0] d;
            e = eq.pop_front();
            d = dq.pop_front();
            chk("model_en", 32'(preview_en), 32'(e));
            chk("model_data", 32'(preview_data), 32'(d));
            chk("model_ready", 32'(next_ready), 32'(exp_ready));
        end
    end

    task automatic step(int x, int y, bit fs, bit nv, logic [39:0] d, int t);
        bit swap, blank, en;
        logic [39:0] ud;
        int ut, cnt_eff;
        @(posedge clk); #1;
        x_addr = x[8:0]; y_addr = y[8:0];
        frame_start = fs; next_valid = nv; next_dots = d; next_type = t[2:0];
        exp_ready = !m_pending;
        swap = fs && m_pending;
        ud = swap ? m_shadow : m_active;
        ut = swap ? m_stype : m_atype;
        blank = 1'b0;
`ifdef TETRIS_PREVIEW_BLINK_EN
        cnt_eff = swap ? 8 : ((fs && m_blink > 0) ? m_blink - 1 : m_blink);
        blank = (cnt_eff != 0) && ((cnt_eff & 2) != 0);
        m_blink = cnt_eff;
`else
        cnt_eff = 0;
`endif
        en = (swap || m_valid) && m_hit(ud, x, y) && !blank;
        eq.push_back(en);
        dq.push_back(en ? colour(ut) : 24'h0);
        if (nv && !m_pending) begin
            m_shadow = d; m_stype = t; m_pending = 1'b1;
        end else if (swap) begin
            m_active = m_shadow; m_atype = m_stype; m_valid = 1'b1; m_pending = 1'b0;
        end
        chk_on = 1'b1;
    endtask

    // Present one pixel, then check the literal expectation once it emerges.
    task automatic lit(string name, int x, int y, bit fs, bit nv, logic [39:0] d, int t,
                       bit e, logic [23:0] dexp);
        step(x, y, fs, nv, d, t);
        step(0, 0, 0, 0, 40'h0, 0);
        step(0, 0, 0, 0, 40'h0, 0);
        chk({name, "_en"}, 32'(preview_en), 32'(e));
        chk({name, "_data"}, 32'(preview_data), 32'(dexp));
    endtask

    logic [39:0] pt, po, pz, pw, pf, rd;

    initial begin
        rst = 1'b0;
        x_addr = '0; y_addr = '0; frame_start = 0; next_valid = 0; next_dots = '0; next_type = '0;
        m_shadow = '0; m_active = '0; m_stype = 0; m_atype = 0; m_blink = 0;
        m_pending = 0; m_valid = 0;
        pt = mk(0,0, 1,0, 2,0, 1,1);
        po = mk(5,5, 6,5, 5,6, 6,6);
        pz = mk(10,10, 11,10, 11,11, 12,11);
        pw = mk(3,3, 3,3, 3,3, 3,3);
        pf = mk(31,31, 31,31, 31,31, 31,31);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_en", 32'(preview_en), 32'd0);
        chk("reset_data", 32'(preview_data), 32'd0);
        chk("reset_ready", 32'(next_ready), 32'd1);
        rst = 1'b1;
        eq.push_back(1'b0); dq.push_back(24'h0);
        eq.push_back(1'b0); dq.push_back(24'h0);

        // nothing loaded yet
        lit("empty", 15, 55, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        for (int i = 0; i < 8; i++) step(i*4, 50 + i*2, 0, 0, 40'h0, 0);

        // T piece: accept, wait, swap with the hit pixel on the swap cycle
        step(0, 0, 0, 1, pt, 2);
        for (int i = 0; i < 4; i++) step(15, 55, 0, 0, 40'h0, 0);
        lit("t_swap", 15, 55, 1, 0, 40'h0, 0, 1'b1, 24'h800080);
        lit("t_gapcol", 10, 55, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("t_corner", 19, 59, 0, 0, 40'h0, 0, 1'b1, 24'h800080);
        lit("t_right", 30, 55, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("t_gaprow", 11, 60, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("t_row1", 11, 61, 0, 0, 40'h0, 0, 1'b1, 24'h800080);
        lit("t_col2end", 29, 59, 0, 0, 40'h0, 0, 1'b1, 24'h800080);

        // accept on frame_start: not swapped until the next one
        lit("o_sameframe", 55, 105, 1, 1, po, 1, 1'b0, 24'h0);
        lit("t_still", 15, 55, 0, 0, 40'h0, 0, 1'b1, 24'h800080);
        for (int i = 0; i < 4; i++) step(105, 155, 0, 1, pz, 4);   // no second accept
        lit("o_swap", 55, 105, 1, 0, 40'h0, 0, 1'b1, 24'hFFFF00);
        lit("o_told", 15, 55, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("o_noz", 105, 155, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("o_idlefs", 55, 105, 1, 0, 40'h0, 0, 1'b1, 24'hFFFF00);

        // duplicate dots, out-of-range type -> white
        step(0, 0, 0, 1, pw, 7);
        lit("w_hit", 35, 85, 1, 0, 40'h0, 0, 1'b1, 24'hFFFFFF);
        lit("w_gap", 30, 85, 0, 0, 40'h0, 0, 1'b0, 24'h0);

        // far cell: no wrap to origin
        step(0, 0, 0, 1, pf, 4);
        lit("f_hit", 315, 365, 1, 0, 40'h0, 0, 1'b1, 24'hFF0000);
        lit("f_origin", 1, 51, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("f_lo", 311, 361, 0, 0, 40'h0, 0, 1'b1, 24'hFF0000);
        lit("f_gap", 310, 361, 0, 0, 40'h0, 0, 1'b0, 24'h0);
        lit("f_hi", 319, 369, 0, 0, 40'h0, 0, 1'b1, 24'hFF0000);
        lit("f_past", 320, 369, 0, 0, 40'h0, 0, 1'b0, 24'h0);

        // mixed traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            bit fs, nv;
            fs = ($urandom_range(0, 19) == 0);
            nv = ($urandom_range(0, 3) == 0);
            if (i % 60 == 0)
                rd = mk(1,1, 2,1, 1,2, 2,2);
            else
                rd = mk($urandom_range(0,8), $urandom_range(0,8), $urandom_range(0,8), $urandom_range(0,8),
                        $urandom_range(0,8), $urandom_range(0,8), $urandom_range(0,8), $urandom_range(0,8));
            step($urandom_range(0, 95), $urandom_range(45, 145), fs, nv, rd, $urandom_range(0, 7));
        end
        step(0, 0, 0, 0, 40'h0, 0);
        @(negedge clk);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tetris_preview_renderer.md
Name: tetris_preview_renderer

Overview:
- Parametrised next-piece preview renderer for the Tetris VGA path.
- Accepts a new piece (N dot coordinates plus piece type) over a valid/ready handshake and holds it in a shadow buffer.
- Swaps the shadow piece into the active piece only at frame start, so the preview never tears mid-frame.
- Produces a 2-stage pipelined pixel enable and a per-type 24-bit colour for the pixel mux.

Parameters:
- NUM_DOTS, 4, cells per piece.
- COL_W, 5, column field width per dot. Column occupies the upper bits of the dot field.
- ROW_W, 5, row field width per dot. Row occupies the lower bits of the dot field.
- TYPE_W, 3, piece type width.
- ADDR_W, 9, x/y pixel address width.
- CELL_W, 10, cell pitch in x, in pixels.
- CELL_H, 10, cell pitch in y, in pixels.
- GAP, 1, blank pixels at the left and top of each cell.
- X_START, 0, preview origin x.
- Y_START, 50, preview origin y.
- BLINK_FRAMES, 8, blink duration in frames. Used only with the optional feature.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- x_addr  in  ADDR_W  current pixel x
- y_addr  in  ADDR_W  current pixel y
- frame_start  in  1  one-cycle pulse at the first pixel of a frame
- next_valid  in  1  new piece offered
- next_ready  out  1  renderer can accept a piece
- next_dots  in  NUM_DOTS*(COL_W+ROW_W)  packed dots; dot 0 in the LSBs
- next_type  in  TYPE_W  piece type
- preview_en  out  1  current pixel belongs to the preview
- preview_data  out  24  RGB888 colour for the current pixel

Behaviour:
- Reset (rst=0, async):
  - preview_en=0, preview_data=0.
  - pending=0, active_valid=0, all pipeline registers 0.
  - next_ready=1 on the first cycle after release.
- Handshake:
  - next_ready = !pending (registered state, no combinational path from next_valid).
  - Accept when next_valid & next_ready: shadow_dots/shadow_type <= inputs, pending <= 1.
- Swap, on frame_start & pending:
  - active <= shadow, active_valid <= 1, pending <= 0.
  - next_ready returns to 1 on the following cycle.
- Accept and frame_start in the same cycle with pending=0: the piece goes to shadow, pending=1. It is not swapped that cycle; it swaps at the next frame_start.
- frame_start with pending=0: no change.
- Cell hit for dot i, with col c and row r:
  - x in [X_START + CELL_W*c + GAP, X_START + CELL_W*(c+1) - 1]
  - y in [Y_START + CELL_H*r + GAP, Y_START + CELL_H*(r+1) - 1]
  - Bounds are inclusive.
- Arithmetic:
  - Bounds are computed at ADDR_W + max(COL_W,ROW_W) + 4 bits, unsigned.
  - A cell extending past 2^ADDR_W-1 is clipped, never wrapped.
- Pipeline:
  - Stage 1 registers the per-dot hit vector and the active type.
  - Stage 2 registers preview_en = active_valid & |hits, and preview_data.
  - preview_data = colour_lut(type) when preview_en, else 0.
  - Latency is exactly 2 clk from x_addr/y_addr to the outputs.
- Overlapping dots (duplicate coords): same single enable, no error.
- Type outside 0..6 maps to white 24'hFFFFFF.
- A swap takes effect for pixels presented from the swap cycle onward; outputs reflect it 2 cycles later.

Optional Feature:
- Macro: TETRIS_PREVIEW_BLINK_EN.
- Defined:
  - Each swap loads blink_cnt <= BLINK_FRAMES.
  - Each later frame_start decrements blink_cnt while it is non-zero.
  - While blink_cnt != 0 and blink_cnt[1]==1, preview_en is forced 0 and preview_data is 0. The effect is 2 frames off, 2 frames on.
  - A new swap reloads the counter. Reset clears it.
- Undefined: no counter exists; the preview is always shown when hit.

Decomposition:
- Package tetris_preview_pkg:
  - piece type constants I,O,T,S,Z,J,L = 0..6.
  - 7-entry RGB888 colour LUT plus the default white.
  - Dot field width localparams.
- One sub-module, preview_cell_hit: combinational bounds compare for one dot, instantiated NUM_DOTS times by generate.

Test Plan:
- Reset, then drive pixels before any piece is loaded -> preview_en=0 and preview_data=0 everywhere; next_ready=1.
- Accept a T piece (type 2) with dots (0,0),(1,0),(2,0),(1,1), then frame_start -> next_ready low until the swap. After the swap, x=15,y=55 gives preview_en=1 and T colour 2 cycles later.
- Boundary with the same T piece -> x=10,y=55 (gap column) gives 0. x=19,y=59 gives 1. x=30,y=55 gives 0. x=11,y=60 gives 0 (gap row of row 1, col 1). x=11,y=61 gives 1.
- next_valid and frame_start in the same cycle with pending=0 -> the piece is not shown in this frame; it is shown after the next frame_start. next_valid held while pending -> no second accept.
- Dot col=31, row=31 with defaults -> no wrap; no pixel near the origin lights.
- With TETRIS_PREVIEW_BLINK_EN, swap a piece with BLINK_FRAMES=8 -> the hit pixel is enabled in the swap frame. It is blanked at frame_starts 1–2, shown at 3–4, blanked at 5–6, and shown permanently from 7 on.
